// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator evaluation chain.
// The sequencer FSM states, error codes and stage indices live here.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_EMPTY   = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_STAGE   = 2'd3
    } err_code_t;

    localparam int STG_NUMBUILD = 0;
    localparam int STG_POSTFIX  = 1;
    localparam int STG_EVAL     = 2;

    // A single stage still needs a one-bit index.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage run timer: cleared on launch, counts while a stage is active,
// saturates and flags expiry once TIMEOUT cycles have elapsed.
module stage_timer
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count_r;
    logic          expired_s;

    assign expired_s = (count_r == TW'(TIMEOUT));
    assign expired   = expired_s;

    // Cycle counter; holds at TIMEOUT so the flag stays stable until cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {TW{1'b0}};
        end else if (clr) begin
            count_r <= {TW{1'b0}};
        end else if (en && !expired_s) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Run controller for the calculator chain: launches each stage in turn on a
// start edge, waits for its completion and reports done / error status.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int TIMEOUT    = 1023,
    parameter int SIZE_W     = 4,
    localparam int SW        = idx_width(NUM_STAGES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [SIZE_W-1:0]     tokenCount,
    input  logic [NUM_STAGES-1:0] stageDone,
    input  logic [NUM_STAGES-1:0] stageErr,
    output logic [NUM_STAGES-1:0] stageGo,
    output logic [SW-1:0]         curStage,
    output logic                  busy,
    output logic                  resultValid,
    output logic                  error,
    output logic [1:0]            errCode
);

    seq_state_t            state_r;
    seq_state_t            next_state_s;
    logic [SW-1:0]         cur_stage_r;
    logic [SW-1:0]         next_stage_s;
    logic                  result_valid_r;
    logic                  next_valid_s;
    logic                  error_r;
    logic                  next_error_s;
    err_code_t             err_code_r;
    err_code_t             next_code_s;
    logic [NUM_STAGES-1:0] stage_go_r;
    logic [NUM_STAGES-1:0] next_go_s;
    logic                  busy_r;
    logic                  next_busy_s;
    logic                  start_prev_r;
    logic                  start_armed_r;
    logic                  start_edge_s;
    logic                  sel_done_s;
    logic                  sel_err_s;
    logic                  timer_clr_s;
    logic                  timer_en_s;
    logic                  timer_expired_s;

    // After reset a start that is already high must first be seen low.
    assign start_edge_s = start & ~start_prev_r & start_armed_r;
    assign sel_done_s   = stageDone[cur_stage_r];
    assign sel_err_s    = stageErr[cur_stage_r];
    assign timer_clr_s  = (next_state_s == ST_LAUNCH);
    assign timer_en_s   = (state_r == ST_LAUNCH) || (state_r == ST_WAIT);

    stage_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stage_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state and status decode; clear overrides everything else.
    always_comb begin
        next_state_s = state_r;
        next_stage_s = cur_stage_r;
        next_valid_s = result_valid_r;
        next_error_s = error_r;
        next_code_s  = err_code_r;
        if (clear) begin
            next_state_s = ST_IDLE;
            next_valid_s = 1'b0;
            next_error_s = 1'b0;
            next_code_s  = ERR_NONE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_edge_s) begin
                        if (tokenCount == {SIZE_W{1'b0}}) begin
                            next_state_s = ST_ERROR;
                            next_valid_s = 1'b0;
                            next_error_s = 1'b1;
                            next_code_s  = ERR_EMPTY;
                        end else begin
                            next_state_s = ST_LAUNCH;
                            next_stage_s = SW'(STG_NUMBUILD);
                            next_valid_s = 1'b0;
                            next_error_s = 1'b0;
                            next_code_s  = ERR_NONE;
                        end
                    end else begin
                        next_state_s = state_r;
                    end
                end
                ST_LAUNCH: begin
                    next_state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (sel_err_s) begin
                        next_state_s = ST_ERROR;
                        next_error_s = 1'b1;
                        next_code_s  = ERR_STAGE;
                    end else if (sel_done_s) begin
                        if (cur_stage_r == SW'(NUM_STAGES - 1)) begin
                            next_state_s = ST_DONE;
                            next_valid_s = 1'b1;
                        end else begin
                            next_state_s = ST_LAUNCH;
                            next_stage_s = cur_stage_r + SW'(1);
                        end
                    end else if (timer_expired_s) begin
                        next_state_s = ST_ERROR;
                        next_error_s = 1'b1;
                        next_code_s  = ERR_TIMEOUT;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_valid_s = 1'b0;
                    next_error_s = 1'b0;
                    next_code_s  = ERR_NONE;
                end
            endcase
        end
    end

    // Launch pulse and busy flag are decoded from the state being entered.
    always_comb begin
        next_go_s   = {NUM_STAGES{1'b0}};
        next_busy_s = 1'b0;
        if (next_state_s == ST_LAUNCH) begin
            next_go_s   = NUM_STAGES'(1) << next_stage_s;
            next_busy_s = 1'b1;
        end else if (next_state_s == ST_WAIT) begin
            next_busy_s = 1'b1;
        end else begin
            next_busy_s = 1'b0;
        end
    end

    // State, status outputs and start edge history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cur_stage_r    <= {SW{1'b0}};
            result_valid_r <= 1'b0;
            error_r        <= 1'b0;
            err_code_r     <= ERR_NONE;
            stage_go_r     <= {NUM_STAGES{1'b0}};
            busy_r         <= 1'b0;
            start_prev_r   <= 1'b0;
            start_armed_r  <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            cur_stage_r    <= next_stage_s;
            result_valid_r <= next_valid_s;
            error_r        <= next_error_s;
            err_code_r     <= next_code_s;
            stage_go_r     <= next_go_s;
            busy_r         <= next_busy_s;
            start_prev_r   <= start;
            start_armed_r  <= start_armed_r | ~start;
        end
    end

    assign stageGo     = stage_go_r;
    assign curStage    = cur_stage_r;
    assign busy        = busy_r;
    assign resultValid = result_valid_r;
    assign error       = error_r;
    assign errCode     = err_code_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a cycle-level reference model
// compared on every falling edge, plus hand-computed spot checks.
module tb_calc_sequencer;

    localparam int NS  = 3;
    localparam int TMO = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] tokenCount = 4'd0;
    logic [2:0] stageDone = 3'b000;
    logic [2:0] stageErr  = 3'b000;
    logic [2:0] stageGo;
    logic [1:0] curStage;
    logic       busy;
    logic       resultValid;
    logic       error;
    logic [1:0] errCode;

    int n_cmp = 0;
    int n_bad = 0;

    calc_sequencer #(
        .NUM_STAGES (NS),
        .TIMEOUT    (TMO),
        .SIZE_W     (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .tokenCount  (tokenCount),
        .stageDone   (stageDone),
        .stageErr    (stageErr),
        .stageGo     (stageGo),
        .curStage    (curStage),
        .busy        (busy),
        .resultValid (resultValid),
        .error       (error),
        .errCode     (errCode)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is "active" with an age counted from its go pulse.
    typedef struct {
        bit busy;
        bit valid;
        bit err;
        int code;
        int stage;
        int age;
        bit prev;
        bit armed;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(input mstate_t s, input bit st, input bit clr,
                                           input int tok, input logic [2:0] dn,
                                           input logic [2:0] er);
        mstate_t n = s;
        bit edge_s = st && !s.prev && s.armed;
        if (clr) begin
            n.busy = 1'b0; n.valid = 1'b0; n.err = 1'b0; n.code = 0;
        end else if (s.busy) begin
            if (s.age == 0) begin
                n.age = 1;
            end else if (er[s.stage]) begin
                n.busy = 1'b0; n.err = 1'b1; n.code = 3;
            end else if (dn[s.stage]) begin
                if (s.stage == NS - 1) begin
                    n.busy = 1'b0; n.valid = 1'b1;
                end else begin
                    n.stage = s.stage + 1; n.age = 0;
                end
            end else if (s.age == TMO) begin
                n.busy = 1'b0; n.err = 1'b1; n.code = 2;
            end else begin
                n.age = s.age + 1;
            end
        end else if (edge_s) begin
            if (tok == 0) begin
                n.valid = 1'b0; n.err = 1'b1; n.code = 1;
            end else begin
                n.busy = 1'b1; n.valid = 1'b0; n.err = 1'b0; n.code = 0;
                n.stage = 0; n.age = 0;
            end
        end
        n.prev  = st;
        n.armed = s.armed || !st;
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m <= '{default: 0};
        end else begin
            m <= model_step(m, start, clear, int'(tokenCount), stageDone, stageErr);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        int exp_go;
        exp_go = (m.busy && m.age == 0) ? (1 << m.stage) : 0;
        check("stageGo", int'(stageGo), exp_go);
        check("curStage", int'(curStage), m.stage);
        check("busy", int'(busy), int'(m.busy));
        check("resultValid", int'(resultValid), int'(m.valid));
        check("error", int'(error), int'(m.err));
        check("errCode", int'(errCode), m.code);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int go_seen;
        #2 reset = 1'b0;
        repeat (3) step();
        check("rst_busy", int'(busy), 0);
        check("rst_go", int'(stageGo), 0);
        check("rst_valid", int'(resultValid), 0);
        check("rst_err", int'(error), 0);
        check("rst_code", int'(errCode), 0);
        check("rst_stage", int'(curStage), 0);
        reset = 1'b1;
        repeat (2) step();

        // Nominal run: done 4, 7, 2 cycles after each go, stray done[0] in stage 1.
        tokenCount = 4'd5; start = 1'b1;
        step();
        check("nom_go0", int'(stageGo), 1);
        check("nom_busy", int'(busy), 1);
        repeat (4) step();
        stageDone = 3'b001;
        step(); stageDone = 3'b000;
        check("nom_go1", int'(stageGo), 2);
        repeat (3) step();
        stageDone = 3'b001;
        step(); stageDone = 3'b000;
        check("stray_busy", int'(busy), 1);
        check("stray_stage", int'(curStage), 1);
        check("stray_go", int'(stageGo), 0);
        repeat (3) step();
        stageDone = 3'b010;
        step(); stageDone = 3'b000;
        check("nom_go2", int'(stageGo), 4);
        repeat (2) step();
        stageDone = 3'b100;
        step(); stageDone = 3'b000;
        check("nom_valid", int'(resultValid), 1);
        check("nom_busy_end", int'(busy), 0);
        check("nom_code", int'(errCode), 0);
        repeat (3) step();
        check("held_start_no_retrigger", int'(busy), 0);

        // Empty input.
        start = 1'b0; tokenCount = 4'd0;
        step(); start = 1'b1;
        step();
        check("empty_err", int'(error), 1);
        check("empty_code", int'(errCode), 1);
        check("empty_valid", int'(resultValid), 0);
        check("empty_go", int'(stageGo), 0);
        clear = 1'b1;
        step(); clear = 1'b0;
        check("clr_err", int'(error), 0);
        check("clr_code", int'(errCode), 0);

        // Timeout in stage 1: error exactly 9 cycles after stageGo[1].
        start = 1'b0; tokenCount = 4'd3;
        step(); start = 1'b1;
        step();
        check("tmo_go0", int'(stageGo), 1);
        step(); stageDone = 3'b001;
        step(); stageDone = 3'b000;
        check("tmo_go1", int'(stageGo), 2);
        repeat (8) step();
        check("tmo_not_yet", int'(error), 0);
        step();
        check("tmo_err", int'(error), 1);
        check("tmo_code", int'(errCode), 2);
        check("tmo_stage", int'(curStage), 1);

        // Stage error in stage 2, restarted directly from ERROR.
        start = 1'b0;
        step(); start = 1'b1; tokenCount = 4'd7;
        step();
        check("serr_go0", int'(stageGo), 1);
        check("serr_cleared", int'(error), 0);
        step(); stageDone = 3'b001;
        step(); stageDone = 3'b000;
        step(); stageDone = 3'b010;
        step(); stageDone = 3'b000;
        check("serr_go2", int'(stageGo), 4);
        step(); stageErr = 3'b110;
        step(); stageErr = 3'b000;
        check("serr_err", int'(error), 1);
        check("serr_code", int'(errCode), 3);
        check("serr_busy", int'(busy), 0);
        clear = 1'b1;
        step(); clear = 1'b0;

        // Abort 3 cycles into stage 0 WAIT; a start edge while busy is dropped.
        start = 1'b0;
        step(); start = 1'b1; tokenCount = 4'd2;
        step();
        check("abort_go0", int'(stageGo), 1);
        step(); start = 1'b0;
        step(); start = 1'b1;
        step(); clear = 1'b1;
        step(); clear = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_go", int'(stageGo), 0);
        go_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (stageGo != 3'b000) go_seen++;
        end
        check("abort_no_go", go_seen, 0);
        start = 1'b0;
        step(); start = 1'b1;
        step();
        check("restart_go0", int'(stageGo), 1);

        // Asynchronous reset during stage 1 WAIT with start held high.
        step(); stageDone = 3'b001;
        step(); stageDone = 3'b000;
        check("rr_go1", int'(stageGo), 2);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_stage", int'(curStage), 0);
        check("arst_go", int'(stageGo), 0);
        step(); step();
        reset = 1'b1;
        repeat (4) step();
        check("rel_no_launch", int'(busy), 0);
        start = 1'b0;
        step(); start = 1'b1;
        step();
        check("rel_go0", int'(stageGo), 1);
        clear = 1'b1;
        step(); clear = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
